// File: rtl/ysyx_23060332_ifu.sv
// rtl/ysyx_23060332_ifu.sv - RV32 instruction fetch unit: PC, single-outstanding imem fetch, decode handshake
// Optional YSYX_23060332_IFU_ALIGN_CHECK_EN: misaligned redirect raises sticky misalign_o and halts fetch.
module ysyx_23060332_ifu #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [ADDR_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              r_kill;
    logic              w_kill_next;
    logic              w_capture;
    logic [ADDR_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic [ADDR_W-1:0] w_redir_target;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic              w_req_hs;

    // Low two bits are forced to zero; masking keeps every redirect bit in use.
    assign w_redir_target = redirect_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    assign w_pc_plus4     = r_pc + {{(ADDR_W-3){1'b0}}, 3'b100};
    assign w_req_hs       = (r_state == S_REQ) && imem_req_ready;

`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
    logic r_misalign;
    logic w_bad_redir;
    assign w_bad_redir = redirect_en && (redirect_addr[1:0] != 2'b00);
    assign misalign_o  = r_misalign;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                if (redirect_en) begin
                    w_pc_next = w_redir_target;
                end
            end
            S_REQ: begin
                if (redirect_en) begin
                    w_pc_next = w_redir_target;
                    if (w_req_hs) begin
                        w_state_next = S_WAIT;
                        w_kill_next  = 1'b1;
                    end
                end else if (w_req_hs) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_en) begin
                    w_pc_next = w_redir_target;
                    if (imem_rsp_valid) begin
                        w_state_next = S_REQ;
                        w_kill_next  = 1'b0;
                    end else begin
                        w_kill_next  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_kill) begin
                        w_state_next = S_REQ;
                        w_kill_next  = 1'b0;
                    end else begin
                        w_state_next = S_HOLD;
                        w_capture    = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_en) begin
                    w_pc_next    = w_redir_target;
                    w_state_next = S_REQ;
                end else if (inst_ready) begin
                    w_pc_next    = w_pc_plus4;
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
        // Once halted the unit parks in S_IDLE until reset; late responses are ignored there.
        if (r_misalign || w_bad_redir) begin
            w_state_next = S_IDLE;
            w_capture    = 1'b0;
            w_kill_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_inst      <= '0;
            r_inst_addr <= '0;
        end else begin
            r_pc   <= w_pc_next;
            r_kill <= w_kill_next;
            if (w_capture) begin
                r_inst      <= imem_rsp_data;
                r_inst_addr <= r_pc;
            end
        end
    end

`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_bad_redir) begin
            r_misalign <= 1'b1;
        end
    end
`endif

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst_o         = r_inst;
    assign inst_addr_o    = r_inst_addr;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// tb/tb_ysyx_23060332_ifu.sv - directed self-checking bench for ysyx_23060332_ifu
module tb_ysyx_23060332_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int iv_cnt = 0;
    int rq0 = 0;
    int rt0 = 0;
    int iv0 = 0;
    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic [31:0] ret_a[$];
    logic [31:0] ret_d[$];

    ysyx_23060332_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
        .misalign_o     (misalign_o),
`endif
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory: fixed latency counted from the accepting edge.
    initial begin : mem_model
        logic        hs;
        logic [31:0] ha;
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = 32'h0;
        cnt = 0;
        forever begin
            @(negedge clk);
            hs = rst_n && imem_req_valid && imem_req_ready;
            ha = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend = 1'b1;
                    cnt = mem_lat;
                    paddr = ha;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data = word_at(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                req_q.push_back(imem_req_addr);
                req_cyc.push_back(cyc);
            end
            if (inst_valid) iv_cnt <= iv_cnt + 1;
            if (inst_valid && inst_ready) begin
                ret_a.push_back(inst_addr_o);
                ret_d.push_back(inst_o);
            end
        end
    end

    function automatic logic [31:0] req_at(input int i);
        return (req_q.size() > rq0 + i) ? req_q[rq0 + i] : 32'hDEAD_DEAD;
    endfunction
    function automatic int req_cyc_at(input int i);
        return (req_cyc.size() > rq0 + i) ? req_cyc[rq0 + i] : -1000;
    endfunction
    function automatic logic [31:0] ret_a_at(input int i);
        return (ret_a.size() > rt0 + i) ? ret_a[rt0 + i] : 32'hDEAD_DEAD;
    endfunction
    function automatic logic [31:0] ret_d_at(input int i);
        return (ret_d.size() > rt0 + i) ? ret_d[rt0 + i] : 32'hDEAD_DEAD;
    endfunction

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        redirect_en = 1'b0;
        inst_ready = 1'b1;
        imem_req_ready = rdy;
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_inst_addr_o", inst_addr_o, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        rq0 = req_q.size();
        rt0 = ret_a.size();
        iv0 = iv_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_hs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req_valid && imem_req_ready) && n < 50);
        check(tag, {31'b0, imem_req_valid && imem_req_ready}, 32'd1);
    endtask

    task automatic wait_iv(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 50);
        check(tag, {31'b0, inst_valid}, 32'd1);
    endtask

    initial begin
        int vcnt;
        // Streaming fetch, always-ready memory, 1-cycle response
        do_reset(1'b1);
        repeat (12) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_req_addr%0d", i), req_at(i), RST_PC + 32'(4 * i));
            check($sformatf("t1_ret_addr%0d", i), ret_a_at(i), RST_PC + 32'(4 * i));
            check($sformatf("t1_ret_data%0d", i), ret_d_at(i), word_at(RST_PC + 32'(4 * i)));
        end
        check("t1_spacing01", 32'(req_cyc_at(1) - req_cyc_at(0)), 32'd3);
        check("t1_spacing12", 32'(req_cyc_at(2) - req_cyc_at(1)), 32'd3);

        // Memory not ready for 4 cycles (reset lands mid-fetch)
        do_reset(1'b0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("t2_req_addr", imem_req_addr, RST_PC);
        end
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;

        // Decode stalls 5 cycles in S_HOLD
        wait_iv("t3_wait_iv");
        for (int i = 0; i < 5; i++) begin
            check("t3_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("t3_inst_o", inst_o, word_at(RST_PC));
            check("t3_inst_addr", inst_addr_o, RST_PC);
            @(negedge clk);
        end
        check("t3_one_req", 32'(req_q.size() - rq0), 32'd1);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        repeat (5) @(posedge clk);
        check("t3_ret0", ret_a_at(0), RST_PC);
        check("t3_next_req", req_at(1), RST_PC + 32'd4);

        // Redirect while waiting; late response must be dropped
        mem_lat = 3;
        do_reset(1'b1);
        wait_hs("t4_hs0");
        @(posedge clk);
        #1;
        redirect_en = 1'b1;
        redirect_addr = 32'h8000_0100;
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
        mem_lat = 1;
        wait_hs("t4_hs1");
        check("t4_req_addr", imem_req_addr, 32'h8000_0100);
        check("t4_no_inst_valid", 32'(iv_cnt - iv0), 32'd0);
        wait_iv("t4_wait_iv");
        check("t4_inst_addr", inst_addr_o, 32'h8000_0100);
        check("t4_inst_o", inst_o, word_at(32'h8000_0100));

        // Redirect in S_HOLD with inst_ready=1
        redirect_en = 1'b1;
        redirect_addr = 32'h8000_0200;
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
        wait_hs("t5_hs");
        check("t5_req_addr", imem_req_addr, 32'h8000_0200);
        check("t5_ret_last", ret_a[ret_a.size() - 1], 32'h8000_0100);

        // PC wrap from FFFF_FFFC
        wait_iv("t5w_iv0");
        redirect_en = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
        wait_hs("t5w_hs0");
        check("t5w_req_top", imem_req_addr, 32'hFFFF_FFFC);
        wait_iv("t5w_iv1");
        check("t5w_inst_addr", inst_addr_o, 32'hFFFF_FFFC);
        check("t5w_inst_o", inst_o, word_at(32'hFFFF_FFFC));
        wait_hs("t5w_hs1");
        check("t5w_wrap", imem_req_addr, 32'h0000_0000);

        // Redirect in the same cycle as the request handshake
        redirect_en = 1'b1;
        redirect_addr = 32'h8000_0300;
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
        wait_iv("t7_iv");
        check("t7_inst_addr", inst_addr_o, 32'h8000_0300);
        check("t7_inst_o", inst_o, word_at(32'h8000_0300));

        // Misaligned redirect target
        wait_iv("t6_iv");
        redirect_en = 1'b1;
        redirect_addr = 32'h8000_0102;
        @(posedge clk);
        #1;
        redirect_en = 1'b0;
`ifdef YSYX_23060332_IFU_ALIGN_CHECK_EN
        @(negedge clk);
        check("t6_misalign", {31'b0, misalign_o}, 32'd1);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid || inst_valid) vcnt++;
            @(negedge clk);
        end
        check("t6_halted", 32'(vcnt), 32'd0);
        check("t6_misalign_sticky", {31'b0, misalign_o}, 32'd1);
`else
        vcnt = 0;
        wait_hs("t6_hs");
        check("t6_aligned_addr", imem_req_addr, 32'h8000_0100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
